// File: rtl/adc_frame_rx.sv
// adc_frame_rx - 4-lane serial ADC link receiver (14-bit samples, 2 bits/lane/CLK)
//
// Finds the frame boundary from the FCO bit pattern 14'h3F80 and checks it with a
// SEARCH / LOCKING / LOCKED alignment FSM. In LOCKED it emits one deserialized
// 4x14-bit sample per 7-cycle frame.
//
// Optional feature: define ADC_RX_BASELINE_EN to subtract BASELINE from every
// channel. Results below zero clamp to 0. The subtraction happens in the output
// register, so latency is unchanged. Without the macro, raw samples pass through.
//
// Ports:
//   CLK            bit-pair clock (DCO rate), rising edge
//   RST            synchronous, active-high reset
//   FCO_BITS[1:0]  FCO pair, [1] earlier bit
//   DATA_BITS[7:0] lane pairs, [2*ch+1] earlier / [2*ch] later bit of lane ch
//   CLR_ERR        clears FRAME_ERR_CNT (wins over a same-cycle increment)
//   CH0..CH3       deserialized samples, held until the next emission
//   DATA_VALID     one-cycle strobe, CH0..CH3 valid
//   LOCKED         frame alignment established
//   LOCK_LOST      one-cycle pulse on LOCKED -> SEARCH
//   FRAME_ERR_CNT  saturating count of bad frames seen while LOCKED
module adc_frame_rx #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 2,
  parameter logic [13:0] BASELINE = 14'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  FCO_BITS,
  input  logic [7:0]  DATA_BITS,
  input  logic        CLR_ERR,
  output logic [13:0] CH0,
  output logic [13:0] CH1,
  output logic [13:0] CH2,
  output logic [13:0] CH3,
  output logic        DATA_VALID,
  output logic        LOCKED,
  output logic        LOCK_LOST,
  output logic [7:0]  FRAME_ERR_CNT
);

  localparam int          NL      = 4;
  localparam logic [13:0] FCO_PAT = 14'h3F80;
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_CNT);
  localparam logic [3:0]  LOSS_N  = 4'(LOSS_CNT);

  typedef enum logic [1:0] {S_SEARCH, S_LOCKING, S_LOCKED} state_t;

  // Boundary tests run on the history *including* this cycle's incoming pair.
  // That puts DATA_VALID one cycle after the last pair is captured. It also
  // means only 13 stored bits are needed, because 13 + 2 new = 15 bits covers
  // both offsets.
  state_t              state_q;
  logic [12:0]         fco_hist_q;
  logic [NL-1:0][12:0] lane_hist_q;
  logic                off_q;
  logic [2:0]          phase_q;
  logic [3:0]          good_q, bad_q;
  logic [7:0]          err_q;
  logic                dv_q, locked_q, lost_q;
  logic [NL-1:0][13:0] ch_q;

  logic [14:0]         fco_hist_d;
  logic [NL-1:0][14:0] lane_hist_d;
  logic                match0, match1, match_sel;
  logic [NL-1:0][13:0] raw, smp;
  logic [2:0]          phase_inc;
  logic [3:0]          good_inc, bad_inc;
  logic [7:0]          err_inc;

  always_comb begin
    fco_hist_d = {fco_hist_q, FCO_BITS};
    for (int c = 0; c < NL; c++) begin
      lane_hist_d[c] = {lane_hist_q[c], DATA_BITS[2*c+1], DATA_BITS[2*c]};
      raw[c]         = off_q ? lane_hist_d[c][14:1] : lane_hist_d[c][13:0];
`ifdef ADC_RX_BASELINE_EN
      smp[c]         = (raw[c] > BASELINE) ? raw[c] - BASELINE : 14'd0;
`else
      // BASELINE has no effect in this build; masked to zero, no arithmetic.
      smp[c]         = raw[c] | (BASELINE & 14'h0);
`endif
    end
    match0    = (fco_hist_d[13:0] == FCO_PAT);
    match1    = (fco_hist_d[14:1] == FCO_PAT);
    match_sel = off_q ? match1 : match0;
    phase_inc = (phase_q == 3'd6) ? 3'd0 : phase_q + 3'd1;
    good_inc  = good_q + 4'd1;
    bad_inc   = bad_q + 4'd1;
    err_inc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_SEARCH;
      fco_hist_q  <= '0;
      lane_hist_q <= '0;
      off_q       <= 1'b0;
      phase_q     <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      err_q       <= '0;
      dv_q        <= 1'b0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
      ch_q        <= '0;
    end else begin
      fco_hist_q <= fco_hist_d[12:0];
      for (int c = 0; c < NL; c++) lane_hist_q[c] <= lane_hist_d[c][12:0];
      dv_q   <= 1'b0;
      lost_q <= 1'b0;

      case (state_q)
        S_SEARCH: begin
          // Try both offsets every cycle. Offset 0 wins a tie. The frame that
          // just matched counts as the first good one.
          if (match0 || match1) begin
            off_q   <= ~match0;
            phase_q <= 3'd1;
            good_q  <= 4'd1;
            bad_q   <= '0;
            if (LOCK_N == 4'd1) begin
              state_q  <= S_LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q  <= S_LOCKING;
            end
          end
        end
        S_LOCKING: begin
          phase_q <= phase_inc;
          if (phase_q == 3'd0) begin
            if (match_sel) begin
              good_q <= good_inc;
              if (good_inc == LOCK_N) begin
                state_q  <= S_LOCKED;
                locked_q <= 1'b1;
                bad_q    <= '0;
              end
            end else begin
              state_q <= S_SEARCH;
              good_q  <= '0;
            end
          end
        end
        S_LOCKED: begin
          phase_q <= phase_inc;
          if (phase_q == 3'd0) begin
            if (match_sel) begin
              bad_q <= '0;
              dv_q  <= 1'b1;
              ch_q  <= smp;
            end else begin
              bad_q <= bad_inc;
              err_q <= err_inc;
              if (bad_inc == LOSS_N) begin
                state_q  <= S_SEARCH;
                locked_q <= 1'b0;
                lost_q   <= 1'b1;
                good_q   <= '0;
              end
            end
          end
        end
        default: state_q <= S_SEARCH;
      endcase

      // Placed last so that a clear overrides an increment in the same cycle.
      if (CLR_ERR) err_q <= '0;
    end
  end

  assign CH0           = ch_q[0];
  assign CH1           = ch_q[1];
  assign CH2           = ch_q[2];
  assign CH3           = ch_q[3];
  assign DATA_VALID    = dv_q;
  assign LOCKED        = locked_q;
  assign LOCK_LOST     = lost_q;
  assign FRAME_ERR_CNT = err_q;

endmodule
